// File: rtl/spi_master_multi.sv
// ---------------------------------------------------------------------------
// spi_master_multi
//
// Parametrised SPI master. One transfer of DATA_W bits per accepted start
// pulse, MSB first, with runtime CPOL/CPHA selection and NUM_CS one-hot
// active-low chip selects.
//
// Handshake: start is a single-cycle request, honoured only while the block
// is idle. On acceptance the word, slave index and mode are latched, busy
// rises on the following cycle and stays high until the cycle in which done
// pulses for one cycle. done and the MISO_data update happen together; a new
// start may be presented in that same done cycle.
//
// Frame timing (CLK_DIV clk cycles per unit):
//   SETUP : 1 unit, CS asserted, SCK at idle level, MOSI preloaded (cpha=0)
//   XFER  : 2*DATA_W units; SCK toggles at the start of each unit, so the
//           first (leading) edge lands on XFER entry and the 2*DATA_W-th
//           edge returns SCK to its idle level for the final unit
//   HOLD  : 1 unit, CS still asserted, SCK idle
// Start-to-done latency is (2*DATA_W+2)*CLK_DIV+1 clk cycles.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           transfer request (sampled in IDLE only)
//   MOSI_data       word to send
//   cs_sel          slave index; values >= NUM_CS select no slave
//   cpol, cpha      SPI mode
//   busy, done      transfer status
//   MISO_data       last received word
//   MISO            serial input
//   MOSI, SCK       serial output and clock
//   CS_n            active-low chip selects
//   state_dbg       current FSM state (IDLE=0, SETUP=1, XFER=2, HOLD=3)
// ---------------------------------------------------------------------------
module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1,
  parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] MOSI_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] MISO_data,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic [NUM_CS-1:0] CS_n,
  output logic [1:0]        state_dbg
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              cpha_q;

  logic              div_last;
  logic              edge_fire;
  logic [EDGE_W-1:0] edge_idx;
  logic [NUM_CS-1:0] cs_dec;

  assign state_dbg = state;

  // One-hot active-low decode of the requested slave. An out-of-range index
  // matches no bit, so the frame runs with every select left high.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  // SCK edge scheduling. Edge index 0 is produced on the SETUP->XFER
  // transition; edges 1..2*DATA_W-1 are produced at each later unit
  // boundary inside XFER. Even indices are leading edges, odd trailing.
  always_comb begin
    div_last  = (div_cnt == DIV_LAST);
    edge_fire = 1'b0;
    edge_idx  = '0;
    if (state == S_SETUP) begin
      edge_fire = div_last;
      edge_idx  = '0;
    end else if (state == S_XFER) begin
      edge_fire = div_last && (edge_cnt != EDGE_LAST);
      edge_idx  = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cpha_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      MISO_data <= '0;
      MOSI      <= 1'b0;
      SCK       <= 1'b0;
      CS_n      <= '1;
    end else begin
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          SCK  <= cpol;
          MOSI <= 1'b0;
          CS_n <= '1;
          if (start) begin
            state    <= S_SETUP;
            busy     <= 1'b1;
            CS_n     <= cs_dec;
            cpha_q   <= cpha;
            rx_sh    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            // tx_sh[MSB] always holds the next bit to put on MOSI. With
            // cpha=0 the MSB goes out immediately, so the register starts
            // one bit ahead.
            if (cpha) begin
              tx_sh <= MOSI_data;
            end else begin
              tx_sh <= {MOSI_data[DATA_W-2:0], 1'b0};
              MOSI  <= MOSI_data[DATA_W-1];
            end
          end
        end

        S_SETUP: begin
          if (div_last) begin
            state    <= S_XFER;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_XFER: begin
          if (div_last) begin
            div_cnt <= '0;
            if (edge_cnt == EDGE_LAST) begin
              state <= S_HOLD;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (div_last) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            CS_n      <= '1;
            MOSI      <= 1'b0;
            MISO_data <= rx_sh;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase

      if (edge_fire) begin
        SCK <= ~SCK;
        if (!edge_idx[0]) begin
          // Leading edge: cpha=1 launches a bit, cpha=0 captures one.
          if (cpha_q) begin
            MOSI  <= tx_sh[DATA_W-1];
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          end else begin
            rx_sh <= {rx_sh[DATA_W-2:0], MISO};
          end
        end else begin
          // Trailing edge: cpha=1 captures, cpha=0 launches the next bit.
          // The final trailing edge has no next bit, so MOSI keeps the LSB.
          if (cpha_q) begin
            rx_sh <= {rx_sh[DATA_W-2:0], MISO};
          end else if (edge_idx != EDGE_LAST) begin
            MOSI  <= tx_sh[DATA_W-1];
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
